// File: rtl/hazard_unit_param_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding select codes,
// the "operand not used" Tuse marker and default multiply/divide latencies.
package hazard_unit_param_pkg;

  typedef logic [1:0] fwd_sel_t;

  // Forwarding mux select codes (D uses all four, E/M use RF/W/M only).
  localparam fwd_sel_t FWD_RF = 2'd0;
  localparam fwd_sel_t FWD_W  = 2'd1;
  localparam fwd_sel_t FWD_M  = 2'd2;
  localparam fwd_sel_t FWD_E  = 2'd3;

  localparam int unsigned TW_DEFAULT = 2;

  // All-ones Tuse marks an operand the instruction never reads.
  localparam logic [TW_DEFAULT-1:0] TUSE_NONE = '1;

  localparam int unsigned MULT_LAT_DEFAULT = 5;
  localparam int unsigned DIV_LAT_DEFAULT  = 10;

endpackage

// File: rtl/hazard_unit_param_md_busy_ctr.sv
// HI/LO busy counter: loaded when a mult/div sits in E, counts down to zero.
module hazard_unit_param_md_busy_ctr
  import hazard_unit_param_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] MultLoad = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DivLoad  = CW'(DIV_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on a start in E, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? DivLoad : MultLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit_param.sv
// Pipeline hazard unit for the 5-stage core: tracks E/M/W destinations and
// Tnew, generates stall/flush controls and D/E/M forwarding selects.
module hazard_unit_param
  import hazard_unit_param_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned TW       = TW_DEFAULT,
  parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEFAULT,
  parameter bit          EN_MD    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              en_pc,
  output logic              en_d,
  output logic              clr_e,
  output logic              md_busy,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic [REG_AW-1:0] a3_w
);

  localparam logic [TW-1:0] TuseUnused = {TW{1'b1}};

  logic [REG_AW-1:0] e_rs_q, e_rt_q, e_a3_q, m_rt_q, m_a3_q, w_a3_q;
  logic [TW-1:0]     e_tnew_q, m_tnew_q, w_tnew_q;
  logic              e_md_start_q, e_md_div_q;
  logic              stall, stall_rs, stall_rt, stall_md;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // A producer forwards only once its result exists (Tnew == 0); $0 never matches.
  function automatic logic is_hit(input logic [REG_AW-1:0] a3, input logic [TW-1:0] tnew,
                                  input logic [REG_AW-1:0] x);
    return (a3 == x) && (a3 != '0) && (tnew == '0);
  endfunction

  // Stall when the consumer needs the value before the producer in E or M has it.
  function automatic logic needs_stall(input logic [REG_AW-1:0] x, input logic [TW-1:0] tuse,
                                       input logic [REG_AW-1:0] a3_e, input logic [TW-1:0] tnew_e,
                                       input logic [REG_AW-1:0] a3_m, input logic [TW-1:0] tnew_m);
    if (tuse == TuseUnused || x == '0) return 1'b0;
    return ((a3_e == x) && (tuse < tnew_e)) || ((a3_m == x) && (tuse < tnew_m));
  endfunction

  // Stage tracking: E takes D or a bubble, M and W always advance with Tnew ageing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs_q       <= '0;
      e_rt_q       <= '0;
      e_a3_q       <= '0;
      e_tnew_q     <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      m_rt_q       <= '0;
      m_a3_q       <= '0;
      m_tnew_q     <= '0;
      w_a3_q       <= '0;
      w_tnew_q     <= '0;
    end else begin
      if (stall) begin
        e_rs_q       <= '0;
        e_rt_q       <= '0;
        e_a3_q       <= '0;
        e_tnew_q     <= '0;
        e_md_start_q <= 1'b0;
        e_md_div_q   <= 1'b0;
      end else begin
        e_rs_q       <= d_rs;
        e_rt_q       <= d_rt;
        e_a3_q       <= d_a3;
        e_tnew_q     <= d_tnew;
        e_md_start_q <= d_md_start;
        e_md_div_q   <= d_md_div;
      end
      m_rt_q   <= e_rt_q;
      m_a3_q   <= e_a3_q;
      m_tnew_q <= sat_dec(e_tnew_q);
      w_a3_q   <= m_a3_q;
      w_tnew_q <= sat_dec(m_tnew_q);
    end
  end

  generate
    if (EN_MD) begin : g_md
      hazard_unit_param_md_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
      ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start_q),
        .is_div (e_md_div_q),
        .busy   (md_busy)
      );
    end else begin : g_no_md
      assign md_busy = 1'b0;
    end
  endgenerate

  // Stall decision; an MD user also waits while a start is still sitting in E.
  always_comb begin
    stall_rs = needs_stall(d_rs, d_tuse_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    stall_rt = needs_stall(d_rt, d_tuse_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    stall_md = d_md_use && (md_busy || e_md_start_q);
    stall    = stall_rs || stall_rt || stall_md;
    en_pc    = ~stall;
    en_d     = ~stall;
    clr_e    = stall;
  end

  // Forwarding selects: D prefers E > M > W, E prefers M > W, M store data from W.
  always_comb begin
    fwd_rs_d = FWD_RF;
    if      (is_hit(e_a3_q, e_tnew_q, d_rs)) fwd_rs_d = FWD_E;
    else if (is_hit(m_a3_q, m_tnew_q, d_rs)) fwd_rs_d = FWD_M;
    else if (is_hit(w_a3_q, w_tnew_q, d_rs)) fwd_rs_d = FWD_W;

    fwd_rt_d = FWD_RF;
    if      (is_hit(e_a3_q, e_tnew_q, d_rt)) fwd_rt_d = FWD_E;
    else if (is_hit(m_a3_q, m_tnew_q, d_rt)) fwd_rt_d = FWD_M;
    else if (is_hit(w_a3_q, w_tnew_q, d_rt)) fwd_rt_d = FWD_W;

    fwd_rs_e = FWD_RF;
    if      (is_hit(m_a3_q, m_tnew_q, e_rs_q)) fwd_rs_e = FWD_M;
    else if (is_hit(w_a3_q, w_tnew_q, e_rs_q)) fwd_rs_e = FWD_W;

    fwd_rt_e = FWD_RF;
    if      (is_hit(m_a3_q, m_tnew_q, e_rt_q)) fwd_rt_e = FWD_M;
    else if (is_hit(w_a3_q, w_tnew_q, e_rt_q)) fwd_rt_e = FWD_W;

    fwd_rt_m = is_hit(w_a3_q, w_tnew_q, m_rt_q);
  end

  assign a3_w = w_a3_q;

endmodule

// File: tb/tb_hazard_unit_param.sv
// Directed bench for hazard_unit_param with a queue-based scoreboard: each
// stimulus cycle pushes its expected outputs, a monitor pops and compares.
module tb_hazard_unit_param;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] a3;
    logic [1:0] tnew;
    logic       md_start, md_div, md_use;
  } d_t;

  typedef struct packed {
    logic       en_pc, en_d, clr_e, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       fwd_rt_m;
    logic [4:0] a3_w;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] d_rs, d_rt, d_a3, a3_w;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       en_pc, en_d, clr_e, md_busy, fwd_rt_m;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  out_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  hazard_unit_param dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .en_pc      (en_pc),
    .en_d       (en_d),
    .clr_e      (clr_e),
    .md_busy    (md_busy),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .fwd_rt_m   (fwd_rt_m),
    .a3_w       (a3_w)
  );

  function automatic d_t mkd(input int rs, input int rt, input int tr, input int tt, input int a3,
                             input int tn, input bit st, input bit dv, input bit us);
    d_t d;
    d.rs = 5'(rs); d.rt = 5'(rt); d.tuse_rs = 2'(tr); d.tuse_rt = 2'(tt);
    d.a3 = 5'(a3); d.tnew = 2'(tn); d.md_start = st; d.md_div = dv; d.md_use = us;
    return d;
  endfunction

  function automatic out_t mk(input bit stall, input bit busy, input int frd, input int frtd,
                              input int fre, input int frte, input bit frm, input int a3w);
    out_t o;
    o.en_pc = ~stall; o.en_d = ~stall; o.clr_e = stall; o.md_busy = busy;
    o.fwd_rs_d = 2'(frd); o.fwd_rt_d = 2'(frtd); o.fwd_rs_e = 2'(fre); o.fwd_rt_e = 2'(frte);
    o.fwd_rt_m = frm; o.a3_w = 5'(a3w);
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("en_pc=%0b en_d=%0b clr_e=%0b busy=%0b frs_d=%0d frt_d=%0d frs_e=%0d frt_e=%0d frt_m=%0b a3_w=%0d",
                     o.en_pc, o.en_d, o.clr_e, o.md_busy, o.fwd_rs_d, o.fwd_rt_d, o.fwd_rs_e,
                     o.fwd_rt_e, o.fwd_rt_m, o.a3_w);
  endfunction

  task automatic step(input string n, input d_t d, input out_t e);
    @(posedge clk);
    #1;
    d_rs = d.rs; d_rt = d.rt; d_tuse_rs = d.tuse_rs; d_tuse_rt = d.tuse_rt;
    d_a3 = d.a3; d_tnew = d.tnew; d_md_start = d.md_start; d_md_div = d.md_div;
    d_md_use = d.md_use;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      out_t  e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{en_pc, en_d, clr_e, md_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, a3_w};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got {%s} expected {%s}", n, fmt(a), fmt(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    d_t   idle;
    out_t nil;
    idle = mkd(0, 0, 3, 3, 0, 0, 0, 0, 0);
    nil  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_a3 = '0; d_tnew = '0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;

    // Reset state with a would-be consumer and an MD user on D.
    step("reset_state", mkd(1, 1, 0, 0, 0, 0, 0, 0, 1), nil);
    @(negedge clk);
    #1 reset = 1'b1;

    // ALU result in E forwarded to D, then from M, then W to E.
    step("t1_addu_issue", mkd(0, 0, 3, 3, 1, 0, 0, 0, 0), nil);
    step("t1_fwd_e_to_d", mkd(1, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 3, 0, 0, 0, 0, 0));
    step("t1_fwd_m_to_d_e", mkd(1, 1, 1, 1, 0, 0, 0, 0, 0), mk(0, 0, 2, 2, 2, 0, 0, 0));
    step("t1_fwd_w_to_e", idle, mk(0, 0, 0, 0, 1, 1, 0, 1));

    // Load-use: one bubble, then the consumer reads the load from W in E.
    step("t2_lw_issue", mkd(0, 0, 3, 3, 2, 2, 0, 0, 0), nil);
    step("t2_load_use_stall", mkd(2, 0, 1, 1, 4, 1, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0));
    step("t2_release", mkd(2, 0, 1, 1, 4, 1, 0, 0, 0), nil);
    step("t2_fwd_w_to_e", idle, mk(0, 0, 0, 0, 1, 0, 0, 2));

    // Store data behind a load: no stall, W to M store-data forward.
    step("t3_lw_issue", mkd(0, 0, 3, 3, 3, 2, 0, 0, 0), nil);
    step("t3_sw_no_stall", mkd(0, 3, 1, 2, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0, 4));
    step("t3_sw_in_e", idle, nil);
    step("t3_fwd_w_to_m", idle, mk(0, 0, 0, 0, 0, 0, 1, 3));

    // $0 as destination flowing through E/M/W while D reads $0.
    step("t4_zero_dest_issue", mkd(0, 0, 0, 0, 0, 2, 0, 0, 0), nil);
    step("t4_zero_in_e", mkd(0, 0, 0, 0, 0, 2, 0, 0, 0), nil);
    step("t4_zero_in_m", mkd(0, 0, 0, 0, 0, 2, 0, 0, 0), nil);
    step("t4_zero_in_w", mkd(0, 0, 0, 0, 0, 2, 0, 0, 0), nil);
    step("t4_settle", idle, nil);

    // div then mfhi: 1 stall for the start in E, then DIV_LAT-1 busy cycles.
    step("t5_div_issue", mkd(0, 0, 3, 3, 0, 0, 1, 1, 1), nil);
    step("t5_div_in_e", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      step($sformatf("t5_div_busy_%0d", i), mkd(0, 0, 3, 3, 0, 0, 0, 0, 1),
           mk(1, 1, 0, 0, 0, 0, 0, 0));
    step("t5_div_release", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), nil);

    // mult then mflo: 1 + MULT_LAT-1 stall cycles.
    step("t5_mult_issue", mkd(0, 0, 3, 3, 0, 0, 1, 0, 1), nil);
    step("t5_mult_in_e", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), mk(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step($sformatf("t5_mult_busy_%0d", i), mkd(0, 0, 3, 3, 0, 0, 0, 0, 1),
           mk(1, 1, 0, 0, 0, 0, 0, 0));
    step("t5_mult_release", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), nil);

    // Asynchronous reset in the middle of a divide stall.
    step("t6_div_issue", mkd(0, 0, 3, 3, 0, 0, 1, 1, 1), nil);
    step("t6_div_in_e", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), mk(1, 0, 0, 0, 0, 0, 0, 0));
    step("t6_busy_pre_reset", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), mk(1, 1, 0, 0, 0, 0, 0, 0));
    step("t6_async_reset", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), nil);
    #2 reset = 1'b0;
    step("t6_in_reset", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), nil);
    @(negedge clk);
    #1 reset = 1'b1;
    step("t6_after_reset", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), nil);
    step("t6_count_aborted", mkd(0, 0, 3, 3, 0, 0, 0, 0, 1), nil);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
